// File: rtl/wave_pc_file.sv
// wave_pc_file: per-SIMD program-counter file for NUM_WAVES resident waves.
// Each wave slot is an IDLE/RUNNING/HALTED context holding its own PC.
// Fetch reads current_pc of active_wave. Decode/issue drives the update controls.
// Optional build macro WAVE_PC_RAS_EN adds a RAS_DEPTH-entry return stack per wave,
// which gives call/ret their meaning.

// One wave context: state, PC and (optionally) its return stack.
module wave_pc_ctx #(
  parameter int ADDR_WIDTH = 32,
  parameter int PC_STEP    = 1,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_disp,
  input  logic [ADDR_WIDTH-1:0] i_disp_pc,
  input  logic                  i_upd,
  input  logic                  i_halt,
  input  logic                  i_br,
`ifdef WAVE_PC_RAS_EN
  input  logic                  i_call,
  input  logic                  i_ret,
`endif
  input  logic [ADDR_WIDTH-1:0] i_target,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_running,
  output logic                  o_halted,
  output logic                  o_err
);
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} st_e;

  st_e                   r_st, w_st_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt, w_pc_seq;

  assign w_pc_seq = r_pc + ADDR_WIDTH'(PC_STEP);

`ifdef WAVE_PC_RAS_EN
  localparam int SP_W  = $clog2(RAS_DEPTH + 1);
  localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [ADDR_WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [SP_W-1:0]       r_sp;
  logic                  w_push, w_pop;
  logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;

  assign w_wr_idx = IDX_W'(r_sp);
  assign w_rd_idx = IDX_W'(r_sp - SP_W'(1));
`endif

  // Next state/PC: dispatch overrides everything; then halt > ret > call > branch > step.
  always_comb begin
    w_st_nxt = r_st;
    w_pc_nxt = r_pc;
    o_err    = 1'b0;
`ifdef WAVE_PC_RAS_EN
    w_push   = 1'b0;
    w_pop    = 1'b0;
`endif
    if (i_disp) begin
      w_st_nxt = ST_RUN;
      w_pc_nxt = i_disp_pc;
    end else if (i_upd && r_st == ST_RUN) begin
      if (i_halt) begin
        w_st_nxt = ST_HALT;
`ifdef WAVE_PC_RAS_EN
      end else if (i_ret) begin
        if (r_sp != '0) begin
          w_pc_nxt = r_ras[w_rd_idx];
          w_pop    = 1'b1;
        end else begin
          // Underflow: step on as if the ret were a plain instruction.
          w_pc_nxt = w_pc_seq;
          o_err    = 1'b1;
        end
      end else if (i_call) begin
        // Overflow still jumps; only the return address is lost.
        w_pc_nxt = i_target;
        if (r_sp == SP_W'(RAS_DEPTH)) o_err = 1'b1;
        else                          w_push = 1'b1;
`endif
      end else if (i_br) begin
        w_pc_nxt = i_target;
      end else begin
        w_pc_nxt = w_pc_seq;
      end
    end
  end

  // Context state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= ST_IDLE;
      r_pc <= '0;
    end else begin
      r_st <= w_st_nxt;
      r_pc <= w_pc_nxt;
    end
  end

`ifdef WAVE_PC_RAS_EN
  // Return stack: emptying the pointer is enough to discard old entries.
  always_ff @(posedge clk) begin
    if (rst || i_disp) begin
      r_sp <= '0;
    end else if (w_push) begin
      r_ras[w_wr_idx] <= w_pc_seq;
      r_sp            <= r_sp + SP_W'(1);
    end else if (w_pop) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end
`endif

  assign o_pc      = r_pc;
  assign o_running = (r_st == ST_RUN);
  assign o_halted  = (r_st == ST_HALT);
endmodule

// Top: slot decode, legality checks, read mux and the sticky error flag.
module wave_pc_file #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_WAVES  = 5,
  parameter int WAVE_ID_W  = 3,
  parameter int PC_STEP    = 1,
  parameter int RAS_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WAVE_ID_W-1:0]  active_wave,
  input  logic                  dispatch_valid,
  input  logic [WAVE_ID_W-1:0]  dispatch_wave,
  input  logic [ADDR_WIDTH-1:0] dispatch_pc,
  input  logic                  update_pc,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  halt,
  input  logic                  call,
  input  logic                  ret,
  output logic [ADDR_WIDTH-1:0] current_pc,
  output logic [NUM_WAVES-1:0]  wave_running,
  output logic [NUM_WAVES-1:0]  wave_halted,
  output logic                  err
);
  logic [NUM_WAVES-1:0]                 w_disp_hit, w_act_hit, w_upd_slot, w_ctx_err;
  logic [NUM_WAVES-1:0][ADDR_WIDTH-1:0] w_pc;
  logic                                 w_same, w_act_run, w_disp_bad, w_upd_bad;
  logic                                 r_err;

`ifndef WAVE_PC_RAS_EN
  logic w_unused_ras;
  assign w_unused_ras = call ^ ret;
`endif

  // One-hot slot decode. An out-of-range index simply matches no slot.
  always_comb begin
    w_disp_hit = '0;
    w_act_hit  = '0;
    for (int i = 0; i < NUM_WAVES; i++) begin
      w_disp_hit[i] = dispatch_valid && (dispatch_wave == WAVE_ID_W'(i));
      w_act_hit[i]  = (active_wave == WAVE_ID_W'(i));
    end
  end

  // A same-slot dispatch silently swallows the update.
  assign w_same     = |(w_disp_hit & w_act_hit);
  assign w_act_run  = |(w_act_hit & wave_running);
  assign w_upd_slot = (update_pc && !w_same) ? (w_act_hit & wave_running) : '0;
  assign w_disp_bad = dispatch_valid && (w_disp_hit == '0);
  assign w_upd_bad  = update_pc && !w_same && !w_act_run;

  genvar g;
  generate
    for (g = 0; g < NUM_WAVES; g++) begin : g_ctx
      wave_pc_ctx #(
        .ADDR_WIDTH(ADDR_WIDTH), .PC_STEP(PC_STEP), .RAS_DEPTH(RAS_DEPTH)
      ) u_ctx (
        .clk      (clk),
        .rst      (rst),
        .i_disp   (w_disp_hit[g]),
        .i_disp_pc(dispatch_pc),
        .i_upd    (w_upd_slot[g]),
        .i_halt   (halt),
        .i_br     (branch_taken),
`ifdef WAVE_PC_RAS_EN
        .i_call   (call),
        .i_ret    (ret),
`endif
        .i_target (branch_target),
        .o_pc     (w_pc[g]),
        .o_running(wave_running[g]),
        .o_halted (wave_halted[g]),
        .o_err    (w_ctx_err[g])
      );
    end
  endgenerate

  // Read mux: active_wave selects a context, and no match reads 0.
  always_comb begin
    current_pc = '0;
    for (int i = 0; i < NUM_WAVES; i++)
      if (w_act_hit[i]) current_pc = w_pc[i];
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= r_err | w_disp_bad | w_upd_bad | (|w_ctx_err);
  end

  assign err = r_err;
endmodule

// File: tb/tb_wave_pc_file.sv
// Directed bench for wave_pc_file. A high-level reference model, updated on every
// clock edge, is compared against the DUT on each falling edge. Literal checks pin
// the model at key points. Also build with WAVE_PC_RAS_EN to cover the return stack.
module tb_wave_pc_file;
  localparam int N  = 5;
  localparam int AW = 32;
  localparam int WW = 3;

  logic          clk = 0, rst = 1;
  logic [WW-1:0] active_wave = '0, dispatch_wave = '0;
  logic          dispatch_valid = 0, update_pc = 0, branch_taken = 0, halt = 0, call = 0, ret = 0;
  logic [AW-1:0] dispatch_pc = '0, branch_target = '0;
  logic [AW-1:0] current_pc;
  logic [N-1:0]  wave_running, wave_halted;
  logic          err;

  int n_vec = 0, n_bad = 0;
  bit chk_en = 0;

  wave_pc_file dut (
    .clk(clk), .rst(rst), .active_wave(active_wave),
    .dispatch_valid(dispatch_valid), .dispatch_wave(dispatch_wave), .dispatch_pc(dispatch_pc),
    .update_pc(update_pc), .branch_taken(branch_taken), .branch_target(branch_target),
    .halt(halt), .call(call), .ret(ret),
    .current_pc(current_pc), .wave_running(wave_running), .wave_halted(wave_halted), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = idle, 1 = running, 2 = halted.
  int            m_st [N];
  logic [AW-1:0] m_pc [N];
  logic [AW-1:0] m_ras[N][$];
  bit            m_err;

  always @(posedge clk) begin
    int a, d;
    bit dok, same;
    a = int'(active_wave);
    d = int'(dispatch_wave);
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_st[i] = 0; m_pc[i] = '0; m_ras[i].delete(); end
      m_err = 0;
    end else begin
      dok  = dispatch_valid && d < N;
      same = dok && d == a;
      if (dispatch_valid && !dok) m_err = 1;
      if (update_pc && !same) begin
        if (a >= N || m_st[a] != 1) m_err = 1;
        else if (halt) m_st[a] = 2;
`ifdef WAVE_PC_RAS_EN
        else if (ret) begin
          if (m_ras[a].size() == 0) begin m_pc[a] = m_pc[a] + 1; m_err = 1; end
          else m_pc[a] = m_ras[a].pop_back();
        end else if (call) begin
          if (m_ras[a].size() >= 4) m_err = 1;
          else m_ras[a].push_back(m_pc[a] + 1);
          m_pc[a] = branch_target;
        end
`endif
        else if (branch_taken) m_pc[a] = branch_target;
        else m_pc[a] = m_pc[a] + 1;
      end
      if (dok) begin m_st[d] = 1; m_pc[d] = dispatch_pc; m_ras[d].delete(); end
    end
  end

  task automatic check(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    logic [AW-1:0] epc;
    logic [N-1:0]  erun, ehlt;
    if (chk_en) begin
      epc = (int'(active_wave) < N) ? m_pc[int'(active_wave)] : '0;
      for (int i = 0; i < N; i++) begin erun[i] = (m_st[i] == 1); ehlt[i] = (m_st[i] == 2); end
      check("model_pc",  current_pc,          epc);
      check("model_run", AW'(wave_running),   AW'(erun));
      check("model_hlt", AW'(wave_halted),    AW'(ehlt));
      check("model_err", AW'(err),            AW'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic disp(input int w, input logic [AW-1:0] pc);
    dispatch_valid = 1; dispatch_wave = WW'(w); dispatch_pc = pc;
    tick();
    dispatch_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  initial begin
    tick(); tick(); rst = 0; chk_en = 1;
    check("rst_pc", current_pc, 0);
    check("rst_run", AW'(wave_running), 0);
    check("rst_hlt", AW'(wave_halted), 0);
    check("rst_err", AW'(err), 0);

    // Sequential stepping on wave 2.
    active_wave = 2; disp(2, 32'h100);
    check("t1_pc0", current_pc, 32'h100);
    update_pc = 1;
    tick(); check("t1_pc1", current_pc, 32'h101);
    tick(); check("t1_pc2", current_pc, 32'h102);
    tick(); check("t1_pc3", current_pc, 32'h103);
    update_pc = 0;
    check("t1_run", AW'(wave_running), AW'(5'b00100));

    // Independent contexts.
    disp(0, 32'h10); disp(4, 32'h40);
    active_wave = 0; update_pc = 1; tick(); tick(); update_pc = 0;
    active_wave = 4; #1 check("t2_w4", current_pc, 32'h40);
    active_wave = 0; #1 check("t2_w0", current_pc, 32'h12);

    // Branch, then wraparound.
    disp(1, 32'h20); active_wave = 1;
    update_pc = 1; branch_taken = 1; branch_target = 32'h80; tick();
    check("t3_br", current_pc, 32'h80);
    branch_taken = 0; tick(); update_pc = 0;
    check("t3_seq", current_pc, 32'h81);
    disp(3, 32'hFFFF_FFFF); active_wave = 3; update_pc = 1; tick(); update_pc = 0;
    check("t3_wrap", current_pc, 32'h0);

`ifndef WAVE_PC_RAS_EN
    // Without the stack, call is ignored: plain step, no error.
    update_pc = 1; call = 1; ret = 1; tick(); update_pc = 0; call = 0; ret = 0;
    check("noras_pc", current_pc, 32'h1);
    check("noras_err", AW'(err), 0);
`endif

    // Halt, then an illegal update, then re-dispatch.
    active_wave = 1; update_pc = 1; halt = 1; tick(); update_pc = 0; halt = 0;
    check("t4_hlt", AW'(wave_halted[1]), 1);
    check("t4_run", AW'(wave_running[1]), 0);
    check("t4_pc", current_pc, 32'h81);
    check("t4_err0", AW'(err), 0);
    update_pc = 1; tick(); update_pc = 0;
    check("t4_pc2", current_pc, 32'h81);
    check("t4_err1", AW'(err), 1);
    disp(1, 32'h0);
    check("t4_rerun", AW'(wave_running[1]), 1);
    check("t4_unhlt", AW'(wave_halted[1]), 0);

    // Same-slot dispatch and update, then different slots, then a bad slot.
    do_reset();
    active_wave = 3; update_pc = 1; disp(3, 32'h200); update_pc = 0;
    check("t5_pc", current_pc, 32'h200);
    check("t5_err", AW'(err), 0);
    update_pc = 1; disp(0, 32'h300); update_pc = 0;
    check("t5_both", current_pc, 32'h201);
    check("t5_run", AW'(wave_running), AW'(5'b01001));
    disp(6, 32'h999);
    check("t5_bad", AW'(err), 1);
    check("t5_same", AW'(wave_running), AW'(5'b01001));
    active_wave = 6; #1 check("t5_oob_rd", current_pc, 0);

`ifdef WAVE_PC_RAS_EN
    // Call/ret round trip, then ret on an empty stack.
    do_reset(); active_wave = 0; disp(0, 32'h10);
    update_pc = 1; call = 1; branch_target = 32'h50; tick();
    check("r_call", current_pc, 32'h50);
    call = 0; ret = 1; tick();
    check("r_ret", current_pc, 32'h11);
    check("r_err0", AW'(err), 0);
    tick(); ret = 0; update_pc = 0;
    check("r_empty", current_pc, 32'h12);
    check("r_err1", AW'(err), 1);
    // Five nested calls overflow on the fifth; the jump still happens.
    do_reset(); disp(0, 32'h10); update_pc = 1; call = 1;
    for (int k = 1; k <= 4; k++) begin
      branch_target = AW'(k * 32'h100); tick();
    end
    check("r_full_err0", AW'(err), 0);
    branch_target = 32'h500; tick(); call = 0;
    check("r_ovf_pc", current_pc, 32'h500);
    check("r_ovf_err", AW'(err), 1);
    ret = 1; tick(); check("r_pop1", current_pc, 32'h301);
    tick(); tick(); tick(); check("r_pop4", current_pc, 32'h11);
    ret = 0; update_pc = 0;
`endif

    tick(); tick();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
